// File: rtl/branch_resolve.sv
// branch_resolve -- branch outcome resolution with a 2-bit saturating BHT.
//
// Resolves one control-flow instruction per cycle: evaluates the selected
// compare on a/b, produces a registered next-PC select and a mispredict flag
// one cycle later, trains a table of 2-bit saturating counters on
// conditional branches, and keeps saturating branch/mispredict statistics.
// The fetch side gets a combinational taken prediction for lookup_pc.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   in_valid            resolve request this cycle
//   a, b                compare operands (N bits)
//   comp_ctrl           compare select (EQ/NE/LT/GE/LTU/GEU, funct3 style)
//   Branch, Jump, Jalr  instruction class
//   pc                  PC of the resolving instruction (selects BHT entry)
//   pred_taken_in       prediction this instruction received at fetch
//   lookup_pc           fetch-side PC for prediction
//   clear_stats         synchronous clear of both statistics counters
//   pred_taken          combinational prediction for lookup_pc
//   out_valid           registered result valid (in_valid delayed one cycle)
//   PCSrc               registered next-PC select: 00 PC+4, 01 target, 10 jalr
//   mispredict          registered conditional-branch mispredict flag
//   branch_count        resolved conditional branches (saturating)
//   mispredict_count    mispredicted conditional branches (saturating)

module branch_resolve #(
    parameter int N     = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [2:0]       comp_ctrl,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             Jalr,
    input  logic [N-1:0]     pc,
    input  logic             pred_taken_in,
    input  logic [N-1:0]     lookup_pc,
    input  logic             clear_stats,
    output logic             pred_taken,
    output logic             out_valid,
    output logic [1:0]       PCSrc,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    // Compare encodings follow the RISC-V branch funct3 values; 010 and 011
    // are undefined and resolve as "not a conditional branch".
    localparam logic [2:0] COMP_EQ  = 3'b000;
    localparam logic [2:0] COMP_NE  = 3'b001;
    localparam logic [2:0] COMP_LT  = 3'b100;
    localparam logic [2:0] COMP_GE  = 3'b101;
    localparam logic [2:0] COMP_LTU = 3'b110;
    localparam logic [2:0] COMP_GEU = 3'b111;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam logic [1:0] CTR_WEAK_NT = 2'b01;
    localparam int         IDX_W       = $clog2(DEPTH);

    logic [1:0]       bht [DEPTH];
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] update_idx;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_next;

    logic             comp_defined;
    logic             taken;
    logic             is_cond;
    logic             mispredict_next;
    logic [1:0]       pcsrc_next;

    // Word-aligned PCs: bits [1:0] never vary, so the index starts at bit 2.
    assign lookup_idx = lookup_pc[IDX_W+1:2];
    assign update_idx = pc[IDX_W+1:2];

    // Reads the stored value, so a same-cycle update is not visible yet.
    assign pred_taken = bht[lookup_idx][1];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{pc[N-1:IDX_W+2], pc[1:0],
                                lookup_pc[N-1:IDX_W+2], lookup_pc[1:0]};

    // Compare evaluation.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        comp_defined = 1'b1;
        taken        = 1'b0;
        case (comp_ctrl)
            COMP_EQ:  taken = (a == b);
            COMP_NE:  taken = (a != b);
            COMP_LT:  taken = ($signed(a) <  $signed(b));
            COMP_GE:  taken = ($signed(a) >= $signed(b));
            COMP_LTU: taken = (a <  b);
            COMP_GEU: taken = (a >= b);
            default:  comp_defined = 1'b0;
        endcase
    end

    assign is_cond         = in_valid & Branch & ~Jump & ~Jalr & comp_defined;
    assign mispredict_next = is_cond & (taken ^ pred_taken_in);

    // Next-PC select: unconditional classes win over the compare result.
    always_comb begin
        pcsrc_next = PCSRC_SEQ;
        if (in_valid) begin
            if (Jump)
                pcsrc_next = PCSRC_TARGET;
            else if (Jalr)
                pcsrc_next = PCSRC_JALR;
            else if (is_cond && taken)
                pcsrc_next = PCSRC_TARGET;
        end
    end

    // Saturating counter step for the entry being trained.
    always_comb begin
        ctr_cur  = bht[update_idx];
        ctr_next = ctr_cur;
        if (taken) begin
            if (ctr_cur != 2'b11)
                ctr_next = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00)
                ctr_next = ctr_cur - 2'b01;
        end
    end

    // Branch history table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the table is built from flops, not a RAM macro, so it can
            // and must be cleared by the async reset to a known bias.
            for (int i = 0; i < DEPTH; i++)
                bht[i] <= CTR_WEAK_NT;
        end else if (is_cond) begin
            bht[update_idx] <= ctr_next;
        end
    end

    // Registered resolve result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its inputs from before the edge.
            out_valid  <= 1'b0;
            PCSrc      <= PCSRC_SEQ;
            mispredict <= 1'b0;
        end else begin
            out_valid  <= in_valid;
            PCSrc      <= pcsrc_next;
            mispredict <= mispredict_next;
        end
    end

    // Statistics: saturate at all-ones; clear wins over a same-cycle count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (clear_stats) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (is_cond && (branch_count != '1))
                branch_count <= branch_count + CNT_W'(1);
            if (mispredict_next && (mispredict_count != '1))
                mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve (N=32, DEPTH=16, CNT_W=4).
// Stimulus tasks compute expectations from a behavioural model and queue
// them; an independent monitor on the falling edge pops and compares.

module tb_branch_resolve;

    localparam int N     = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [2:0] C_EQ  = 3'b000;
    localparam logic [2:0] C_NE  = 3'b001;
    localparam logic [2:0] C_LT  = 3'b100;
    localparam logic [2:0] C_GE  = 3'b101;
    localparam logic [2:0] C_LTU = 3'b110;
    localparam logic [2:0] C_GEU = 3'b111;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [N-1:0]     a, b;
    logic [2:0]       comp_ctrl;
    logic             Branch, Jump, Jalr;
    logic [N-1:0]     pc;
    logic             pred_taken_in;
    logic [N-1:0]     lookup_pc;
    logic             clear_stats;
    logic             pred_taken;
    logic             out_valid;
    logic [1:0]       PCSrc;
    logic             mispredict;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    branch_resolve #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .a                (a),
        .b                (b),
        .comp_ctrl        (comp_ctrl),
        .Branch           (Branch),
        .Jump             (Jump),
        .Jalr             (Jalr),
        .pc               (pc),
        .pred_taken_in    (pred_taken_in),
        .lookup_pc        (lookup_pc),
        .clear_stats      (clear_stats),
        .pred_taken       (pred_taken),
        .out_valid        (out_valid),
        .PCSrc            (PCSrc),
        .mispredict       (mispredict),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  comp;
        bit          br;
        bit          jmp;
        bit          jalr;
        logic [31:0] pc;
        bit          pti;
        logic [31:0] lookup;
        bit          clr;
    } req_t;

    typedef struct {
        logic [1:0] pcsrc;
        bit         mis;
    } exp_t;

    // Reference state: plain integer counters and statistics.
    int   bht_m [DEPTH];
    int   bc_m;
    int   mc_m;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit last_pred;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    // Branch rule: the compare result, or "undefined" for the two spare codes.
    function automatic bit model_taken(input logic [2:0] c, input logic [31:0] x,
                                       input logic [31:0] y, output bit defined);
        int sx, sy;
        sx = int'(x);
        sy = int'(y);
        defined = 1'b1;
        case (c)
            C_EQ:    return x == y;
            C_NE:    return x != y;
            C_LT:    return sx < sy;
            C_GE:    return sx >= sy;
            C_LTU:   return x < y;
            C_GEU:   return x >= y;
            default: begin defined = 1'b0; return 1'b0; end
        endcase
    endfunction

    function automatic req_t idle_req();
        req_t r;
        r.valid = 0; r.a = 0; r.b = 0; r.comp = C_EQ; r.br = 0; r.jmp = 0;
        r.jalr = 0; r.pc = 0; r.pti = 0; r.lookup = 0; r.clr = 0;
        return r;
    endfunction

    // EQ-compare branch whose outcome is chosen directly.
    function automatic req_t br_req(input logic [31:0] p, input bit tk, input bit pti);
        req_t r;
        r = idle_req();
        r.valid = 1; r.br = 1; r.comp = C_EQ; r.a = 32'd5;
        r.b = tk ? 32'd5 : 32'd6; r.pc = p; r.pti = pti; r.lookup = p;
        return r;
    endfunction

    function automatic req_t idle_look(input logic [31:0] lk);
        req_t r;
        r = idle_req();
        r.lookup = lk;
        return r;
    endfunction

    // Drives one cycle of stimulus; called just after a rising edge.
    task automatic issue(input req_t r);
        bit   def, tk, cond;
        exp_t e;
        int   pi;
        in_valid = r.valid; a = r.a; b = r.b; comp_ctrl = r.comp;
        Branch = r.br; Jump = r.jmp; Jalr = r.jalr; pc = r.pc;
        pred_taken_in = r.pti; lookup_pc = r.lookup; clear_stats = r.clr;
        #1;
        last_pred = pred_taken;
        check("pred_taken", pred_taken, bht_m[idx_of(r.lookup)] >= 2);
        tk   = model_taken(r.comp, r.a, r.b, def);
        cond = r.valid && r.br && !r.jmp && !r.jalr && def;
        if (!r.valid)              e.pcsrc = 2'b00;
        else if (r.jmp)            e.pcsrc = 2'b01;
        else if (r.jalr)           e.pcsrc = 2'b10;
        else if (cond && tk)       e.pcsrc = 2'b01;
        else                       e.pcsrc = 2'b00;
        e.mis = cond && (tk != r.pti);
        @(posedge clk);
        if (r.valid) exp_q.push_back(e);
        if (cond) begin
            pi = idx_of(r.pc);
            bht_m[pi] = tk ? ((bht_m[pi] < 3) ? bht_m[pi] + 1 : 3)
                           : ((bht_m[pi] > 0) ? bht_m[pi] - 1 : 0);
        end
        if (r.clr) begin
            bc_m = 0;
            mc_m = 0;
        end else if (cond) begin
            if (bc_m < CNT_MAX) bc_m++;
            if (e.mis && mc_m < CNT_MAX) mc_m++;
        end
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) bht_m[i] = 1;
        bc_m = 0;
        mc_m = 0;
        exp_q.delete();
    endtask

    // Monitor: compares every falling edge against the queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("PCSrc", PCSrc, e.pcsrc);
                    check("mispredict", mispredict, e.mis);
                end
            end else begin
                check("idle_PCSrc", PCSrc, 2'b00);
                check("idle_mispredict", mispredict, 1'b0);
            end
            check("branch_count", branch_count, bc_m);
            check("mispredict_count", mispredict_count, mc_m);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=done");
        $fatal(1);
    end

    initial begin
        req_t r;
        int   saved;

        model_reset();
        reset = 1'b1;
        in_valid = 0; a = 0; b = 0; comp_ctrl = 0; Branch = 0; Jump = 0; Jalr = 0;
        pc = 0; pred_taken_in = 0; lookup_pc = 32'h40; clear_stats = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_PCSrc", PCSrc, 2'b00);
        check("rst_mispredict", mispredict, 1'b0);
        check("rst_branch_count", branch_count, 0);
        check("rst_mispredict_count", mispredict_count, 0);
        check("rst_pred_0x40", pred_taken, 1'b0);
        reset = 1'b0;

        // Counter training at 0x40: 1 -> 3, saturate, then down to 0.
        repeat (2) issue(br_req(32'h40, 1'b1, 1'b0));
        issue(idle_look(32'h40));
        check("train_two_taken", pred_taken, 1'b1);
        repeat (3) issue(br_req(32'h40, 1'b1, 1'b1));
        issue(br_req(32'h40, 1'b0, 1'b1));
        check("train_sat_high", last_pred, 1'b1);
        issue(idle_look(32'h40));
        check("train_3_minus_1", pred_taken, 1'b1);
        repeat (3) issue(br_req(32'h40, 1'b0, 1'b0));
        issue(idle_look(32'h40));
        check("train_four_not_taken", pred_taken, 1'b0);
        issue(br_req(32'h40, 1'b1, 1'b0));
        issue(idle_look(32'h40));
        check("train_sat_low", pred_taken, 1'b0);

        // Signed versus unsigned less-than.
        r = idle_req();
        r.valid = 1; r.br = 1; r.a = 32'hFFFF_FFFF; r.b = 32'd1; r.pc = 32'h108;
        r.comp = C_LT; r.pti = 0; r.lookup = 32'h108;
        issue(r);
        check("lt_signed_PCSrc", PCSrc, 2'b01);
        check("lt_signed_mispredict", mispredict, 1'b1);
        r.comp = C_LTU;
        issue(r);
        check("ltu_PCSrc", PCSrc, 2'b00);
        check("ltu_mispredict", mispredict, 1'b0);

        // Jump and Jalr together: Jump wins, nothing counted.
        saved = bc_m;
        r = idle_req();
        r.valid = 1; r.br = 1; r.jmp = 1; r.jalr = 1; r.pti = 1; r.pc = 32'h20;
        issue(r);
        check("jump_prio_PCSrc", PCSrc, 2'b01);
        check("jump_prio_mispredict", mispredict, 1'b0);
        check("jump_prio_count", branch_count, saved);
        r.jmp = 0;
        issue(r);
        check("jalr_PCSrc", PCSrc, 2'b10);

        // Undefined compare code: no redirect, no count.
        r = br_req(32'h30, 1'b1, 1'b0);
        r.comp = 3'b010;
        issue(r);
        check("undef_PCSrc", PCSrc, 2'b00);
        check("undef_count", branch_count, saved);

        // Aliasing: 0x04 and 0x44 share entry 1; same-cycle lookup sees old value.
        r = br_req(32'h04, 1'b1, 1'b0);
        r.lookup = 32'h44;
        issue(r);
        check("alias_same_cycle_old", last_pred, 1'b0);
        issue(idle_look(32'h44));
        check("alias_updated", pred_taken, 1'b1);

        // Statistics saturation and clear priority.
        r = idle_req();
        r.clr = 1;
        issue(r);
        for (int i = 0; i < 20; i++)
            issue(br_req(32'h80 + 32'(i * 4), i[0], ~i[0]));
        check("sat_branch_count", branch_count, 4'hF);
        check("sat_mispredict_count", mispredict_count, 4'hF);
        r = br_req(32'h84, 1'b1, 1'b0);
        r.clr = 1;
        issue(r);
        check("clear_branch_count", branch_count, 0);
        check("clear_mispredict_count", mispredict_count, 0);

        // Reset mid-stream between two valid requests.
        repeat (3) issue(br_req(32'h40, 1'b1, 1'b0));
        issue(br_req(32'h40, 1'b1, 1'b0));
        reset = 1'b1;
        in_valid = 0; lookup_pc = 32'h40;
        #1;
        model_reset();
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_PCSrc", PCSrc, 2'b00);
        check("midrst_mispredict", mispredict, 1'b0);
        check("midrst_branch_count", branch_count, 0);
        check("midrst_bht", pred_taken, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue(br_req(32'h40, 1'b1, 1'b0));
        check("postrst_out_valid", out_valid, 1'b1);
        check("postrst_PCSrc", PCSrc, 2'b01);
        check("postrst_mispredict", mispredict, 1'b1);
        issue(idle_look(32'h40));
        check("postrst_bht", pred_taken, 1'b1);

        // Randomized back-to-back traffic.
        for (int i = 0; i < 400; i++) begin
            r = idle_req();
            r.valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: begin r.a = $urandom; r.b = r.a; end
                1: begin r.a = $urandom; r.b = $urandom; end
                2: begin r.a = 32'h8000_0000; r.b = 32'($urandom_range(0, 5)); end
                default: begin r.a = 32'($urandom_range(0, 3)); r.b = 32'($urandom_range(0, 3)); end
            endcase
            if ($urandom_range(0, 1) == 1) begin
                logic [31:0] t;
                t = r.a; r.a = r.b; r.b = t;
            end
            r.comp   = 3'($urandom_range(0, 7));
            r.br     = ($urandom_range(0, 9) < 7);
            r.jmp    = ($urandom_range(0, 9) == 0);
            r.jalr   = ($urandom_range(0, 9) == 0);
            r.pc     = $urandom & 32'hFFFF_FFFC;
            r.pti    = $urandom_range(0, 1);
            r.lookup = ($urandom_range(0, 1) == 1) ? r.pc : ($urandom & 32'hFFFF_FFFC);
            r.clr    = ($urandom_range(0, 49) == 0);
            issue(r);
        end

        repeat (2) issue(idle_req());
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
